pe_addr_gen_array: RTL

//  Parametrised bank of NUM_PE per-PE read-address generators for the conv engine's input buffer.

---
 rtl/pe_addr_gen_array_if.sv | 30 +++
 rtl/pe_addr_gen_array.sv | 132 +++++++++++++
 2 files changed

// File: rtl/pe_addr_gen_array_if.sv
// Control, configuration and address bus of the per-PE read-address generator bank.
// The master side drives configuration and consumption strobes; the slave side returns addresses and status.
interface pe_addr_gen_array_if #(
    parameter int unsigned NUM_PE = 16,
    parameter int unsigned ADDR_W = 13,
    parameter int unsigned DIM_W  = 8
);
    logic                     en;
    logic                     start;
    logic [ADDR_W-1:0]        base_addr;
    logic [DIM_W-1:0]         img_w;
    logic [DIM_W-1:0]         out_w;
    logic [DIM_W-1:0]         out_h;
    logic [NUM_PE-1:0]        valid;
    logic [NUM_PE*ADDR_W-1:0] addr;
    logic [NUM_PE-1:0]        pe_done;
    logic                     busy;
    logic                     done;
    logic                     addr_err;

    modport master (
        output en, start, base_addr, img_w, out_w, out_h, valid,
        input  addr, pe_done, busy, done, addr_err
    );

    modport slave (
        input  en, start, base_addr, img_w, out_w, out_h, valid,
        output addr, pe_done, busy, done, addr_err
    );
endinterface

// File: rtl/pe_addr_gen_array.sv
// Bank of NUM_PE read-address generators, each walking an out_w x out_h window over an img_w-pitch map.
// Optional sticky bounds check against MAX_ADDR is built only when ADDR_GEN_BOUNDS_CHK_EN is defined.
module pe_addr_gen_array #(
    parameter int unsigned NUM_PE   = 16,
    parameter int unsigned ADDR_W   = 13,
    parameter int unsigned PE_COLS  = 5,
    parameter int unsigned DIM_W    = 8,
    parameter int unsigned MAX_ADDR = 8191
) (
    input  logic                 clk,
    input  logic                 reset_n,
    pe_addr_gen_array_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t            state, state_nxt;
    logic              accept;
    logic [NUM_PE-1:0] done_q;
    logic [DIM_W-1:0]  img_w_q, out_w_q, out_h_q;
    logic [ADDR_W-1:0] row_step;

    assign accept = (state == IDLE) && bus.start;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (bus.start) state_nxt = (bus.out_w == '0 || bus.out_h == '0) ? DONE : RUN;
            RUN:     if (&done_q) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.busy = (state == RUN);
        bus.done = (state == DONE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            img_w_q <= '0;
            out_w_q <= '0;
            out_h_q <= '0;
        end else if (accept) begin
            img_w_q <= bus.img_w;
            out_w_q <= bus.out_w;
            out_h_q <= bus.out_h;
        end
    end

    // Jump from the last column of one window row to the first column of the next.
    assign row_step = ADDR_W'(img_w_q) - ADDR_W'(out_w_q) + ADDR_W'(1);

`ifdef ADDR_GEN_BOUNDS_CHK_EN
    logic [NUM_PE-1:0] over;
    logic              err_q;
`endif

    for (genvar g = 0; g < NUM_PE; g++) begin : g_pe
        logic [ADDR_W-1:0] addr_q, addr_d, addr_ld;
        logic [DIM_W-1:0]  col_q, col_d, row_q, row_d;
        logic              done_d, adv;

        assign addr_ld = bus.base_addr + ADDR_W'(g / PE_COLS) * ADDR_W'(bus.img_w)
                         + ADDR_W'(g % PE_COLS);
        assign adv     = (state == RUN) && bus.en && bus.valid[g] && !done_q[g];

        always_comb begin
            addr_d = addr_q;
            col_d  = col_q;
            row_d  = row_q;
            done_d = done_q[g];
            if (accept) begin
                addr_d = addr_ld;
                col_d  = '0;
                row_d  = '0;
                done_d = 1'b0;
            end else if (adv) begin
                if (col_q != out_w_q - DIM_W'(1)) begin
                    col_d  = col_q + DIM_W'(1);
                    addr_d = addr_q + ADDR_W'(1);
                end else if (row_q != out_h_q - DIM_W'(1)) begin
                    col_d  = '0;
                    row_d  = row_q + DIM_W'(1);
                    addr_d = addr_q + row_step;
                end else begin
                    done_d = 1'b1;
                end
            end
        end

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                addr_q    <= '0;
                col_q     <= '0;
                row_q     <= '0;
                done_q[g] <= 1'b0;
            end else begin
                addr_q    <= addr_d;
                col_q     <= col_d;
                row_q     <= row_d;
                done_q[g] <= done_d;
            end
        end

        assign bus.addr[g*ADDR_W +: ADDR_W] = addr_q;

`ifdef ADDR_GEN_BOUNDS_CHK_EN
        assign over[g] = (accept || adv) && (32'(addr_d) > MAX_ADDR);
`endif
    end

    assign bus.pe_done = done_q;

`ifdef ADDR_GEN_BOUNDS_CHK_EN
    // An accepted start both clears the flag and checks the freshly loaded addresses.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)    err_q <= 1'b0;
        else if (accept) err_q <= |over;
        else             err_q <= err_q | (|over);
    end

    assign bus.addr_err = err_q;
`else
    assign bus.addr_err = 1'b0;
`endif
endmodule
